noise_burst_ctrl: RTL and testbench
===================================

# noise_burst_ctrl

Burst scheduler for the parallel LFSR noise source. Holds a programmable burst/gap schedule, gates the LFSR advance on a valid/ready output handshake and frames each burst with a last marker. It sits between the control registers and the DAC sample mux, so test-noise bursts come out backpressure-safe and sample-exact.

## Interface
- PARALLEL_SAMPLES, 4: samples per beat, one LFSR lane each.
- SAMPLE_WIDTH, 16: bits per output sample, 1..16. Each sample is the upper SAMPLE_WIDTH bits of its lane.
- LEN_WIDTH, 16: width of the burst and gap counters.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  high only in IDLE.
- cfg_burst_len  in  LEN_WIDTH  beats per burst.
- cfg_gap_len  in  LEN_WIDTH  idle cycles between bursts.
- cfg_repeat  in  1  1 = repeat bursts continuously.
- start  in  1  single-cycle start pulse.
- stop  in  1  single-cycle stop pulse.
- busy  out  1  state != IDLE.
- data_out  out  PARALLEL_SAMPLES*SAMPLE_WIDTH  noise beat, lane 0 in the LSBs.
- data_valid  out  1  beat valid.
- data_ready  in  1  downstream accept.
- data_last  out  1  final beat of the current burst.

## Operation
- States: IDLE, BURST, GAP.
- Config:
  - Latched on cfg_valid && cfg_ready.
  - Registers reset to burst_len=0, gap_len=0, repeat=0.
  - A handshake and start in the same cycle: start uses the new values.
- IDLE:
  - start with burst_len != 0 goes to BURST, beat count = 0.
  - start with burst_len == 0 is ignored.
  - stop has no effect.
- BURST:
  - data_valid=1.
  - A beat is a cycle with data_valid && data_ready; each beat increments the beat count.
  - data_last=1 while count == burst_len-1.
  - After the last beat:
    - repeat=1, gap_len!=0: go to GAP.
    - repeat=1, gap_len==0: start a new BURST immediately; data_valid stays high.
    - repeat=0: go to IDLE.
- GAP:
  - data_valid=0 for exactly gap_len cycles, then BURST.
- stop:
  - In GAP: IDLE on the next cycle.
  - In BURST: clears the run-time repeat flag. The current burst completes all its beats, then goes to IDLE. Bursts are never truncated.
  - stop on the same cycle as the last beat: IDLE next.
- LFSR:
  - enable = data_valid && data_ready, so exactly one PARALLEL_SAMPLES-step advance per beat.
  - The sequence is never reseeded between bursts; consecutive bursts continue one sequence.
- reset:
  - At any time, forces IDLE, clears counters and config, and reseeds the LFSR.
  - Outputs after reset: busy=0, cfg_ready=1, data_valid=0, data_last=0, data_out = seeded lanes (lane0 0xace1, lane1 0xe270, upper bits for SAMPLE_WIDTH<16).

## Timing
- start at cycle t: busy=1 and data_valid=1 at t+1.
- All outputs are registered; data_out comes straight from the LFSR state.
- data_out, data_valid and data_last hold stable while data_valid && !data_ready (AXI-stream rules).
- A beat at cycle t presents the next sample set at t+1.
- Last beat at t:
  - repeat=0: busy=0 at t+1.
  - GAP: data_valid=0 for t+1..t+gap_len, then 1 at t+gap_len+1.
- Burst of N beats with data_ready held high: N consecutive valid cycles.
- Counters: beat count LEN_WIDTH bits, compared against burst_len-1. Max burst 2^LEN_WIDTH-1 beats, no wrap.

## Structure
- Package noise_pkg holds:
  - the state enum typedef;
  - LFSR_POLY (16'hb400) and LFSR_SEED (16'hace1), shared with the LFSR.
- One sub-module: lfsr16_parallel #(PARALLEL_SAMPLES), driven by clk, reset and the handshake enable.
- Lane truncation and the FSM live in noise_burst_ctrl.

## Test plan
- Reset, no stimulus -> busy=0, data_valid=0, cfg_ready=1; data_out lane0=0xace1, lane1=0xe270.
- burst_len=3, repeat=0, data_ready=1, start at t0 -> data_valid t1..t3, data_last only at t3, busy=0 at t4; lane0 after burst = lane0 seed advanced 12 steps.
- Same burst with data_ready pattern 1,0,0,1,0,1 -> data_out frozen on ready=0 cycles; exactly 3 beats; data_last held until accepted.
- burst_len=2, gap_len=2, repeat=1 -> data_valid 1,1,0,0,1,1,0,0…; data_last on every 2nd valid cycle. With gap_len=0 -> data_valid continuously 1, last every 2nd beat.
- burst_len=4, repeat=1: stop during beat 1 -> 4 beats complete, then IDLE, no gap. stop during GAP -> busy=0 next cycle.
- reset asserted mid-BURST -> IDLE, data_out=seed next cycle. cfg_valid during BURST -> cfg_ready=0, config unchanged.

Source files
------------

// File: rtl/noise_pkg.sv
// rtl/noise_pkg.sv - shared state encoding and LFSR constants for the noise burst scheduler
package noise_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_POLY = 16'hb400;
  localparam logic [15:0] LFSR_SEED = 16'hace1;

  // One right-shifting Galois step; the feedback taps come from LFSR_POLY.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  // Advance a lane state by n single steps.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] s, input int n);
    logic [15:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = lfsr_step(v);
    return v;
  endfunction

endpackage

// File: rtl/lfsr16_parallel.sv
// rtl/lfsr16_parallel.sv - PARALLEL_SAMPLES interleaved lanes of one 16-bit Galois LFSR sequence
module lfsr16_parallel
  import noise_pkg::*;
#(
  parameter int PARALLEL_SAMPLES = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  output logic [PARALLEL_SAMPLES*16-1:0] lanes
);

  // Lane i starts i steps into the sequence; every enable moves all lanes
  // PARALLEL_SAMPLES steps so lanes stay interleaved across beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PARALLEL_SAMPLES; i++)
        lanes[i*16 +: 16] <= lfsr_adv(LFSR_SEED, i);
    end else if (enable) begin
      for (int i = 0; i < PARALLEL_SAMPLES; i++)
        lanes[i*16 +: 16] <= lfsr_adv(lanes[i*16 +: 16], PARALLEL_SAMPLES);
    end
  end

endmodule

// File: rtl/noise_burst_ctrl.sv
// rtl/noise_burst_ctrl.sv - burst/gap scheduler with valid/ready framing over the parallel LFSR
module noise_burst_ctrl
  import noise_pkg::*;
#(
  parameter int PARALLEL_SAMPLES = 4,
  parameter int SAMPLE_WIDTH     = 16,
  parameter int LEN_WIDTH        = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  input  logic [LEN_WIDTH-1:0]                   cfg_burst_len,
  input  logic [LEN_WIDTH-1:0]                   cfg_gap_len,
  input  logic                                   cfg_repeat,
  input  logic                                   start,
  input  logic                                   stop,
  output logic                                   busy,
  output logic [PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] data_out,
  output logic                                   data_valid,
  input  logic                                   data_ready,
  output logic                                   data_last
);

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  state_t                 state, state_nx;
  logic [LEN_WIDTH-1:0]   burst_len, gap_len;
  logic                   repeat_cfg;
  logic [LEN_WIDTH-1:0]   beat_cnt, cnt_nx;
  logic [LEN_WIDTH-1:0]   gap_cnt, gap_nx;
  logic                   run_rep, rep_nx;
  logic                   cfg_fire, beat;
  logic [LEN_WIDTH-1:0]   eff_burst;
  logic                   eff_repeat;
  logic [PARALLEL_SAMPLES*16-1:0] lanes;

  assign cfg_fire   = cfg_valid && cfg_ready;
  assign beat       = data_valid && data_ready;
  assign eff_burst  = cfg_fire ? cfg_burst_len : burst_len;
  assign eff_repeat = cfg_fire ? cfg_repeat : repeat_cfg;

  // Config registers; writes only land while idle because cfg_ready gates them.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_len  <= '0;
      gap_len    <= '0;
      repeat_cfg <= 1'b0;
    end else if (cfg_fire) begin
      burst_len  <= cfg_burst_len;
      gap_len    <= cfg_gap_len;
      repeat_cfg <= cfg_repeat;
    end
  end

  // Next-state logic: a started burst always runs to its final beat; stop only
  // suppresses the repeat (or aborts a gap).
  always_comb begin
    state_nx = state;
    cnt_nx   = beat_cnt;
    gap_nx   = gap_cnt;
    rep_nx   = run_rep;
    case (state)
      ST_IDLE: begin
        if (start && eff_burst != '0) begin
          state_nx = ST_BURST;
          cnt_nx   = '0;
          rep_nx   = eff_repeat;
        end
      end
      ST_BURST: begin
        rep_nx = run_rep && !stop;
        if (beat) begin
          if (beat_cnt == burst_len - ONE) begin
            cnt_nx = '0;
            if (!rep_nx) begin
              state_nx = ST_IDLE;
            end else if (gap_len != '0) begin
              state_nx = ST_GAP;
              gap_nx   = '0;
            end
          end else begin
            cnt_nx = beat_cnt + ONE;
          end
        end
      end
      ST_GAP: begin
        if (stop) begin
          state_nx = ST_IDLE;
          rep_nx   = 1'b0;
        end else if (gap_cnt == gap_len - ONE) begin
          state_nx = ST_BURST;
          cnt_nx   = '0;
        end else begin
          gap_nx = gap_cnt + ONE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State and counters plus outputs registered from their next values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      beat_cnt   <= '0;
      gap_cnt    <= '0;
      run_rep    <= 1'b0;
      data_valid <= 1'b0;
      data_last  <= 1'b0;
      busy       <= 1'b0;
      cfg_ready  <= 1'b1;
    end else begin
      state      <= state_nx;
      beat_cnt   <= cnt_nx;
      gap_cnt    <= gap_nx;
      run_rep    <= rep_nx;
      data_valid <= (state_nx == ST_BURST);
      data_last  <= (state_nx == ST_BURST) && (cnt_nx == eff_burst - ONE);
      busy       <= (state_nx != ST_IDLE);
      cfg_ready  <= (state_nx == ST_IDLE);
    end
  end

  lfsr16_parallel #(
    .PARALLEL_SAMPLES(PARALLEL_SAMPLES)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .enable(beat),
    .lanes (lanes)
  );

  // Each sample is the top SAMPLE_WIDTH bits of its lane.
  for (genvar i = 0; i < PARALLEL_SAMPLES; i++) begin : g_lane
    assign data_out[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = lanes[i*16 + 16 - SAMPLE_WIDTH +: SAMPLE_WIDTH];
  end

endmodule

// File: tb/tb_noise_burst_ctrl.sv
// tb/tb_noise_burst_ctrl.sv - directed self-checking bench for noise_burst_ctrl
module tb_noise_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_burst_len;
  logic [15:0] cfg_gap_len;
  logic        cfg_repeat;
  logic        start;
  logic        stop;
  logic        busy;
  logic [63:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic        data_last;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] ref0;
  int          beats;
  logic [5:0]  rdy_pat;

  noise_burst_ctrl #(
    .PARALLEL_SAMPLES(4),
    .SAMPLE_WIDTH    (16),
    .LEN_WIDTH       (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_burst_len(cfg_burst_len),
    .cfg_gap_len  (cfg_gap_len),
    .cfg_repeat   (cfg_repeat),
    .start        (start),
    .stop         (stop),
    .busy         (busy),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .data_last    (data_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] adv(input logic [15:0] s, input int n);
    logic [15:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 16'hb400) : (v >> 1);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [15:0] bl, input logic [15:0] gl, input logic rp);
    cfg_valid     = 1'b1;
    cfg_burst_len = bl;
    cfg_gap_len   = gl;
    cfg_repeat    = rp;
    start         = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_burst_len = '0; cfg_gap_len = '0;
    cfg_repeat = 1'b0; start = 1'b0; stop = 1'b0; data_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_last", data_last, 1'b0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_lane0", data_out[15:0], 16'hace1);
    chk("rst_lane1", data_out[31:16], 16'he270);
    chk("rst_lane2", data_out[47:32], 16'h7138);
    chk("rst_lane3", data_out[63:48], 16'h389c);
    ref0 = 16'hace1;

    // single burst of 3, ready held high
    go(16'd3, 16'd0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk("b3_valid", data_valid, c < 3);
      chk("b3_last", data_last, c == 2);
      chk("b3_busy", busy, c < 3);
      chk("b3_lane0", data_out[15:0], ref0);
      if (c < 3) ref0 = adv(ref0, 4);
      if (c < 3) tick();
    end
    chk("b3_lane0_12", data_out[15:0], adv(16'hace1, 12));

    // same burst under backpressure 1,0,0,1,0,1
    rdy_pat = 6'b101001;
    beats = 0;
    go(16'd3, 16'd0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      data_ready = rdy_pat[c];
      chk("bp_valid", data_valid, 1'b1);
      chk("bp_last", data_last, beats == 2);
      chk("bp_lane0", data_out[15:0], ref0);
      if (rdy_pat[c]) begin
        beats++;
        ref0 = adv(ref0, 4);
      end
      tick();
    end
    data_ready = 1'b1;
    chk("bp_end_valid", data_valid, 1'b0);
    chk("bp_end_busy", busy, 1'b0);
    chk("bp_end_lane0", data_out[15:0], ref0);

    // repeat with gap 2, then stop inside a gap
    go(16'd2, 16'd2, 1'b1);
    for (int c = 0; c < 10; c++) begin
      chk("gap_valid", data_valid, (c % 4) < 2);
      chk("gap_last", data_last, (c % 4) == 1);
      chk("gap_busy", busy, 1'b1);
      chk("gap_lane0", data_out[15:0], ref0);
      if ((c % 4) < 2) ref0 = adv(ref0, 4);
      tick();
    end
    chk("gap_in_gap_valid", data_valid, 1'b0);
    chk("gap_in_gap_busy", busy, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("gap_stop_busy", busy, 1'b0);
    chk("gap_stop_valid", data_valid, 1'b0);
    chk("gap_stop_lane0", data_out[15:0], ref0);

    // repeat with gap 0: back-to-back bursts, stop on the first beat of the 5th
    go(16'd2, 16'd0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      stop = (c == 8);
      chk("b2b_valid", data_valid, 1'b1);
      chk("b2b_last", data_last, (c % 2) == 1);
      chk("b2b_lane0", data_out[15:0], ref0);
      ref0 = adv(ref0, 4);
      tick();
    end
    stop = 1'b0;
    chk("b2b_end_busy", busy, 1'b0);
    chk("b2b_end_valid", data_valid, 1'b0);

    // burst 4, repeat with gap 3, stop during beat 1: finish then idle, no gap
    go(16'd4, 16'd3, 1'b1);
    for (int c = 0; c < 4; c++) begin
      stop = (c == 1);
      chk("stp_valid", data_valid, 1'b1);
      chk("stp_last", data_last, c == 3);
      ref0 = adv(ref0, 4);
      tick();
    end
    stop = 1'b0;
    chk("stp_end_busy", busy, 1'b0);
    chk("stp_end_valid", data_valid, 1'b0);
    chk("stp_end_lane0", data_out[15:0], ref0);

    // config write attempts during a burst are refused
    go(16'd4, 16'd0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      cfg_valid     = (c < 3);
      cfg_burst_len = 16'd1;
      cfg_repeat    = 1'b1;
      chk("cfgb_ready", cfg_ready, 1'b0);
      chk("cfgb_last", data_last, c == 3);
      ref0 = adv(ref0, 4);
      tick();
    end
    cfg_valid = 1'b0;
    chk("cfgb_end_busy", busy, 1'b0);
    chk("cfgb_end_ready", cfg_ready, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("cfgk_valid", data_valid, 1'b1);
      chk("cfgk_last", data_last, c == 3);
      chk("cfgk_lane0", data_out[15:0], ref0);
      ref0 = adv(ref0, 4);
      tick();
    end
    chk("cfgk_end_busy", busy, 1'b0);

    // reset mid-burst reseeds and clears config
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_valid", data_valid, 1'b0);
    chk("mrst_last", data_last, 1'b0);
    chk("mrst_cfg_ready", cfg_ready, 1'b1);
    chk("mrst_lane0", data_out[15:0], 16'hace1);
    chk("mrst_lane1", data_out[31:16], 16'he270);
    reset = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_len_busy", busy, 1'b0);
    chk("zero_len_valid", data_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
